// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: glyph table (active-low {g..a}),
// blank pattern and the scan-decoder state type.
package ssd_pkg;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Display-bus tap plus decoded-word valid/ready handshake.
// master = decoder side, slave = bus driver / word consumer.
interface ssd_scan_decoder_if #(
  parameter int NUM_DIGITS = 2
);
  logic [6:0]              ssd_i;
  logic [NUM_DIGITS-1:0]   an_i;
  logic [4*NUM_DIGITS-1:0] data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic                    err_o;

  modport master (
    input  ssd_i, an_i, ready_i,
    output data_o, valid_o, err_o
  );

  modport slave (
    output ssd_i, an_i, ready_i,
    input  data_o, valid_o, err_o
  );
endinterface

// File: rtl/ssd_glyph_decode.sv
// Combinational inverse of the hex glyph table: pattern -> nibble,
// legal_o low for anything that is not one of the 16 glyphs.
module ssd_glyph_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nib_o,
  output logic       legal_o
);

  always_comb begin
    nib_o   = '0;
    legal_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == GLYPH[i]) begin
        nib_o   = 4'(i);
        legal_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Rebuilds hex words from a multiplexed seven-segment bus.
// Optional SSD_SCAN_DECODER_OVERRUN_EN adds sticky overrun_o.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef SSD_SCAN_DECODER_OVERRUN_EN
  output logic overrun_o,
`endif
  ssd_scan_decoder_if.master bus
);

  localparam int         SW  = NUM_DIGITS + 7;
  localparam int         DW  = 4 * NUM_DIGITS;
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);

  logic [SW-1:0]         samp_q, samp_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  state_e                state_q, state_d;

  logic [NUM_DIGITS-1:0] sel;
  logic [3:0]            nib;
  logic                  legal, changed, commit, sel_ok;

  ssd_glyph_decode u_dec (
    .seg_i   (samp_q[6:0]),
    .nib_o   (nib),
    .legal_o (legal)
  );

  assign samp_d = {bus.an_i, bus.ssd_i};
  assign sel    = ~samp_q[SW-1:7];
  assign sel_ok = $onehot(sel);

  always_comb begin
    changed = (samp_d != samp_q);
    cnt_d   = changed ? 8'd1
            : (cnt_q == STB) ? STB : cnt_q + 8'd1;
    commit  = !changed && (cnt_d == STB) && !done_q;
    done_d  = !changed && (done_q || commit);
  end

  always_comb begin
    shadow_d = shadow_q;
    mask_d   = mask_q;
    data_d   = data_q;
    valid_d  = valid_q;
    state_d  = state_q;
    err_d    = commit && sel_ok && !legal;
    unique case (state_q)
      COLLECT: begin
        if (&mask_q) begin
          data_d  = shadow_q;
          valid_d = 1'b1;
          mask_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (valid_q && bus.ready_i) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end else if (&mask_q) begin
          mask_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
    // commit applies after any clear so a back-to-back capture survives
    if (commit && sel_ok) begin
      if (legal) begin
        mask_d = mask_d | sel;
        for (int k = 0; k < NUM_DIGITS; k++)
          if (sel[k]) shadow_d[4*k +: 4] = nib;
      end else begin
        mask_d = mask_d & ~sel;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      samp_q   <= '1;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      state_q  <= COLLECT;
    end else begin
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      state_q  <= state_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.err_o   = err_q;

`ifdef SSD_SCAN_DECODER_OVERRUN_EN
  logic ovr_q, drop;

  assign drop = (state_q == HOLD) && !(valid_q && bus.ready_i)
              && (&mask_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ovr_q <= 1'b0;
    else         ovr_q <= ovr_q | drop;
  end

  assign overrun_o = ovr_q;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed bench for ssd_scan_decoder (NUM_DIGITS=2, STABLE_CYCLES=4).
// Checks overrun_o too when SSD_SCAN_DECODER_OVERRUN_EN is defined.
module tb_ssd_scan_decoder;

  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0011000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GD = 7'b0100001;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] BL = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;
  int   npass = 0;
  int   ntot  = 0;
  int   errcnt = 0;
  int   acc_cnt = 0;
  int   e0;
  logic [7:0] acc_data = '0;

  ssd_scan_decoder_if #(.NUM_DIGITS(2)) bus ();

`ifdef SSD_SCAN_DECODER_OVERRUN_EN
  logic overrun;
`endif

  ssd_scan_decoder #(
    .NUM_DIGITS    (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
`ifdef SSD_SCAN_DECODER_OVERRUN_EN
    .overrun_o (overrun),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.err_o) errcnt++;
      if (bus.valid_o && bus.ready_i) begin
        acc_cnt++;
        acc_data = bus.data_o;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] an, input logic [6:0] seg);
    bus.an_i  = an;
    bus.ssd_i = seg;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ready_i = 1'b0;
    drive(2'b10, G2);
    step(3);
    chk("rst_data", 32'(bus.data_o), 32'h0);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    chk("rst_mask", 32'(dut.mask_q), 32'h0);

    rst_n = 1'b1;
    step(3);
    chk("pre_commit", 32'(dut.mask_q), 32'h0);
    step(1);
    chk("commit_e4", 32'(dut.mask_q), 32'h1);
    step(2);

    drive(2'b01, G1);
    bus.ready_i = 1'b1;
    step(4);
    chk("basic_v_early", 32'(bus.valid_o), 32'h0);
    chk("basic_mask", 32'(dut.mask_q), 32'h3);
    step(1);
    chk("basic_valid", 32'(bus.valid_o), 32'h1);
    chk("basic_data", 32'(bus.data_o), 32'h12);
    step(1);
    chk("basic_v_drop", 32'(bus.valid_o), 32'h0);
    chk("basic_acc", 32'(acc_data), 32'h12);
    chk("basic_err", 32'(errcnt), 32'h0);

    for (int i = 0; i < 10; i++) begin
      drive(2'b10, (i % 2) ? G9 : G8);
      step(2);
    end
    chk("glitch_mask", 32'(dut.mask_q), 32'h0);
    chk("glitch_valid", 32'(bus.valid_o), 32'h0);
    chk("glitch_err", 32'(errcnt), 32'h0);

    drive(2'b10, G5);
    step(6);
    chk("ill_pre_mask", 32'(dut.mask_q), 32'h1);
    e0 = errcnt;
    drive(2'b10, BL);
    step(3);
    chk("ill_err_early", 32'(bus.err_o), 32'h0);
    step(1);
    chk("ill_err", 32'(bus.err_o), 32'h1);
    chk("ill_mask", 32'(dut.mask_q), 32'h0);
    step(1);
    chk("ill_err_end", 32'(bus.err_o), 32'h0);
    step(3);
    chk("ill_pulses", 32'(errcnt - e0), 32'h1);
    chk("ill_valid", 32'(bus.valid_o), 32'h0);

    bus.ready_i = 1'b0;
    drive(2'b10, GF);
    step(6);
    drive(2'b01, GA);
    step(5);
    chk("bp_valid", 32'(bus.valid_o), 32'h1);
    chk("bp_data", 32'(bus.data_o), 32'haf);
`ifdef SSD_SCAN_DECODER_OVERRUN_EN
    chk("bp_ovr_pre", 32'(overrun), 32'h0);
`endif
    step(1);
    drive(2'b10, GC);
    step(6);
    drive(2'b01, G3);
    step(4);
    chk("bp2_mask", 32'(dut.mask_q), 32'h3);
    step(1);
    chk("bp_drop_mask", 32'(dut.mask_q), 32'h0);
    chk("bp_hold_data", 32'(bus.data_o), 32'haf);
    chk("bp_hold_valid", 32'(bus.valid_o), 32'h1);
`ifdef SSD_SCAN_DECODER_OVERRUN_EN
    chk("bp_overrun", 32'(overrun), 32'h1);
`endif
    step(2);
    chk("bp_hold_data2", 32'(bus.data_o), 32'haf);
    bus.ready_i = 1'b1;
    step(1);
    chk("bp_v_drop", 32'(bus.valid_o), 32'h0);
    chk("bp_acc", 32'(acc_data), 32'haf);
    chk("bp_acc_cnt", 32'(acc_cnt), 32'h2);
    step(4);
    chk("bp_no_3c", 32'(bus.valid_o), 32'h0);

    drive(2'b10, G7);
    step(6);
    chk("mid_pre_mask", 32'(dut.mask_q), 32'h1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_rst_mask", 32'(dut.mask_q), 32'h0);
`ifdef SSD_SCAN_DECODER_OVERRUN_EN
    chk("mid_ovr_clr", 32'(overrun), 32'h0);
`endif
    drive(2'b01, GE);
    step(6);
    chk("mid_mask", 32'(dut.mask_q), 32'h2);
    drive(2'b10, GD);
    step(4);
    chk("mid_v_early", 32'(bus.valid_o), 32'h0);
    step(1);
    chk("mid_valid", 32'(bus.valid_o), 32'h1);
    chk("mid_data", 32'(bus.data_o), 32'hed);
    step(1);
    chk("mid_v_drop", 32'(bus.valid_o), 32'h0);
    chk("mid_acc_cnt", 32'(acc_cnt), 32'h3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
